// File: rtl/risc_sequencer.sv
// Multi-cycle control sequencer for the 16-bit RISC core: fetch over a req/ack
// port, then step each instruction through decode, execute and write-back.
module risc_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             pc_set,
    input  logic [PC_W-1:0]  pc_init,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    output logic [15:0]      instr,
    input  logic             dec_reg_write_enable,
    output logic             alu_en,
    output logic             rf_we,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       state,
    output logic             busy,
    output logic             halted,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    localparam logic [2:0] OP_ILLEGAL = 3'b110;
    localparam logic [2:0] OP_HALT    = 3'b111;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      instr_q, instr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic [2:0]       opcode;

    assign opcode = instr_q[15:13];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Once a fetch is issued the instruction always runs to write-back; run
    // is only sampled at instruction boundaries.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!pc_set && run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_HALT) state_d = S_HALT;
                else                   state_d = S_EXECUTE;
            end
            S_EXECUTE:   state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
            S_HALT: begin
                if (!run) state_d = S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        illegal_d = illegal_q;
        if ((state_q == S_IDLE || state_q == S_HALT) && pc_set) begin
            pc_d = pc_init;
        end
        if (state_q == S_FETCH && imem_ack) begin
            instr_d = imem_rdata;
            pc_d    = pc_q + PC_W'(1);
        end
        if (state_q == S_DECODE && opcode == OP_ILLEGAL) begin
            illegal_d = 1'b1;
        end
        if (state_q == S_WRITEBACK) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // An illegal opcode behaves as a NOP, so its write strobe is suppressed
    // even if the decoder disagrees.
    always_comb begin
        imem_req = (state_q == S_FETCH);
        alu_en   = (state_q == S_EXECUTE);
        rf_we    = (state_q == S_WRITEBACK) && dec_reg_write_enable
                   && (opcode != OP_ILLEGAL);
        busy     = (state_q != S_IDLE) && (state_q != S_HALT);
        halted   = (state_q == S_HALT);
    end

    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign state         = state_q;
    assign retired       = retired_q;
    assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Directed table-driven bench for risc_sequencer with a wait-state memory model.
module tb_risc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        pc_set = 1'b0;
    logic [7:0]  pc_init = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        dec_we = 1'b0;
    logic        alu_en;
    logic        rf_we;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic        busy;
    logic        halted;
    logic        illegal_instr;
    logic [15:0] retired;

    logic [15:0] mem [256];
    int          dly = 0;
    int          wcnt;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_instr = 16'h0000;
    logic [15:0] exp_ret = 16'h0000;
    logic        exp_ill = 1'b0;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] word;
        logic        we;
        int          dly;
        int          cyc;
        int          rf;
        int          alu;
        logic [7:0]  npc;
        logic        halt;
    } vec_t;

    vec_t tbl[7];

    risc_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .run                  (run),
        .pc_set               (pc_set),
        .pc_init              (pc_init),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (imem_ack),
        .imem_rdata           (imem_rdata),
        .instr                (instr),
        .dec_reg_write_enable (dec_we),
        .alu_en               (alu_en),
        .rf_we                (rf_we),
        .pc                   (pc),
        .state                (state),
        .busy                 (busy),
        .halted               (halted),
        .illegal_instr        (illegal_instr),
        .retired              (retired)
    );

    always #5 clk = ~clk;

    // Memory answers after dly wait cycles of an outstanding request.
    assign imem_ack   = imem_req && (wcnt >= dly);
    assign imem_rdata = mem[imem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s act=timeout exp=done", name);
    endtask

    task automatic run_row(input int i);
        vec_t v;
        int   cyc, alu, rf;
        bit   done;
        v = tbl[i];
        @(negedge clk);
        mem[v.pc] = v.word;
        dec_we    = v.we;
        dly       = v.dly;
        pc_set    = 1'b1;
        pc_init   = v.pc;
        @(negedge clk);
        check("pc_set_load", {24'h0, pc}, {24'h0, v.pc});
        pc_set = 1'b0;
        run    = 1'b1;
        cyc = 0; alu = 0; rf = 0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            run = 1'b0;
            if (state == 3'd0 || state == 3'd5) begin
                done = 1'b1;
            end else begin
                cyc++;
                alu += int'(alu_en);
                rf  += int'(rf_we);
                if (state == 3'd1) begin
                    check("fetch_addr_hold", {24'h0, imem_addr}, {24'h0, v.pc});
                    check("fetch_instr_hold", {16'h0, instr}, {16'h0, exp_instr});
                end
            end
        end
        if (!done) timeout("row_complete");
        exp_instr = v.word;
        if (!v.halt) begin
            exp_ret = exp_ret + 16'd1;
            if (v.word[15:13] == 3'b110) exp_ill = 1'b1;
        end
        check("row_cycles", cyc, v.cyc);
        check("row_alu_en", alu, v.alu);
        check("row_rf_we", rf, v.rf);
        check("row_pc", {24'h0, pc}, {24'h0, v.npc});
        check("row_instr", {16'h0, instr}, {16'h0, v.word});
        check("row_retired", {16'h0, retired}, {16'h0, exp_ret});
        check("row_illegal", {31'h0, illegal_instr}, {31'h0, exp_ill});
        check("row_halted", {31'h0, halted}, {31'h0, v.halt});
        check("row_busy", {31'h0, busy}, 32'h0);
        $display("row %0d pc=%0h word=%0h cyc=%0d pc_after=%0h retired=%0d", i, v.pc, v.word, cyc, pc, retired);
        if (v.halt) begin
            @(negedge clk);
            check("halt_to_idle", {29'h0, state}, 32'h0);
        end
    endtask

    task automatic wait_halt(input string name);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            if (halted) hit = 1'b1;
        end
        if (!hit) timeout(name);
    endtask

    initial begin
        int seq[5];
        seq = '{1, 2, 3, 4, 1};
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;

        // pc, word, we, dly, cyc, rf, alu, npc, halt
        tbl[0] = '{8'h00, 16'h0A48, 1'b1, 0, 4, 1, 1, 8'h01, 1'b0};
        tbl[1] = '{8'h05, 16'h1234, 1'b1, 3, 7, 1, 1, 8'h06, 1'b0};
        tbl[2] = '{8'h0A, 16'hC000, 1'b0, 0, 4, 0, 1, 8'h0B, 1'b0};
        tbl[3] = '{8'h14, 16'h2000, 1'b0, 1, 5, 0, 1, 8'h15, 1'b0};
        tbl[4] = '{8'hFF, 16'h0A48, 1'b1, 0, 4, 1, 1, 8'h00, 1'b0};
        tbl[5] = '{8'h1E, 16'hE000, 1'b1, 2, 4, 0, 0, 8'h1F, 1'b0 | 1'b1};
        tbl[6] = '{8'h28, 16'hE5A5, 1'b1, 0, 2, 0, 0, 8'h29, 1'b1};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", {29'h0, state}, 32'h0);
        check("rst_pc", {24'h0, pc}, 32'h0);
        check("rst_instr", {16'h0, instr}, 32'h0);
        check("rst_retired", {16'h0, retired}, 32'h0);
        check("rst_outputs", {26'h0, imem_req, alu_en, rf_we, busy, halted, illegal_instr}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold", {29'h0, state}, 32'h0);

        for (int i = 0; i < 7; i++) run_row(i);

        // Continuous run into HALT, then restart from address 0.
        mem[0] = 16'h0A48; mem[1] = 16'h1111; mem[2] = 16'hE000;
        dly = 0; dec_we = 1'b1;
        @(negedge clk);
        pc_set = 1'b1; pc_init = 8'h00;
        @(negedge clk);
        pc_set = 1'b0; run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("seq_state", {29'h0, state}, seq[k]);
            check("seq_alu_en", {31'h0, alu_en}, (k == 2) ? 32'h1 : 32'h0);
            check("seq_rf_we", {31'h0, rf_we}, (k == 3) ? 32'h1 : 32'h0);
        end
        check("seq_pc_after_wb", {24'h0, pc}, 32'h1);
        check("seq_retired_after_wb", {16'h0, retired}, {16'h0, exp_ret + 16'd1});
        wait_halt("halt_enter");
        exp_ret = exp_ret + 16'd2;
        check("halt_flag", {31'h0, halted}, 32'h1);
        check("halt_pc", {24'h0, pc}, 32'h3);
        check("halt_retired", {16'h0, retired}, {16'h0, exp_ret});
        $display("halt reached pc=%0h retired=%0d", pc, retired);
        @(negedge clk);
        check("halt_holds_run", {29'h0, state}, 32'h5);
        run = 1'b0;
        @(negedge clk);
        check("halt_exit_idle", {29'h0, state}, 32'h0);
        pc_set = 1'b1; pc_init = 8'h00;
        @(negedge clk);
        pc_set = 1'b0; run = 1'b1;
        @(negedge clk);
        check("restart_fetch", {29'h0, state}, 32'h1);
        check("restart_addr", {24'h0, imem_addr}, 32'h0);
        wait_halt("halt_reenter");
        exp_ret = exp_ret + 16'd2;
        check("rerun_retired", {16'h0, retired}, {16'h0, exp_ret});
        check("rerun_pc", {24'h0, pc}, 32'h3);
        run = 1'b0;
        @(negedge clk);
        check("rerun_idle", {29'h0, state}, 32'h0);
        exp_instr = 16'hE000;

        // run dropped during DECODE: instruction still completes.
        mem[8'h32] = 16'h0A48;
        @(negedge clk);
        pc_set = 1'b1; pc_init = 8'h32;
        @(negedge clk);
        pc_set = 1'b0; run = 1'b1;
        @(negedge clk);
        check("drop_fetch", {29'h0, state}, 32'h1);
        @(negedge clk);
        check("drop_decode", {29'h0, state}, 32'h2);
        run = 1'b0;
        @(negedge clk);
        check("drop_execute", {30'h0, state == 3'd3, alu_en}, 32'h3);
        @(negedge clk);
        check("drop_writeback", {30'h0, state == 3'd4, rf_we}, 32'h3);
        @(negedge clk);
        exp_ret = exp_ret + 16'd1;
        check("drop_idle", {29'h0, state}, 32'h0);
        check("drop_busy", {31'h0, busy}, 32'h0);
        check("drop_retired", {16'h0, retired}, {16'h0, exp_ret});
        check("drop_pc", {24'h0, pc}, 32'h33);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("drop_no_req", {31'h0, imem_req}, 32'h0);
        end
        $display("run-drop instruction retired=%0d pc=%0h", retired, pc);

        // Asynchronous reset in the middle of a stalled fetch.
        dly = 5;
        mem[8'h3C] = 16'h1234;
        pc_set = 1'b1; pc_init = 8'h3C;
        @(negedge clk);
        pc_set = 1'b0; run = 1'b1;
        @(negedge clk);
        check("mid_fetch_state", {29'h0, state}, 32'h1);
        @(negedge clk);
        check("mid_fetch_req", {31'h0, imem_req}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_req", {31'h0, imem_req}, 32'h0);
        check("arst_pc", {24'h0, pc}, 32'h0);
        check("arst_instr", {16'h0, instr}, 32'h0);
        check("arst_retired", {16'h0, retired}, 32'h0);
        check("arst_state", {29'h0, state}, 32'h0);
        check("arst_illegal", {31'h0, illegal_instr}, 32'h0);
        $display("async reset mid-fetch pc=%0h retired=%0d", pc, retired);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {29'h0, state}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
